// File: rtl/keypad_scanner_if.sv
// Keypad pin and keycode-event bundle between the scanner and its neighbours.
interface keypad_scanner_if;
    logic [3:0] rows_in;
    logic [3:0] columns_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_release;
    logic       key_down;
    logic       multi_key;

    modport master (
        input  rows_in,
        output columns_out, key_code, key_valid, key_release, key_down, multi_key
    );

    modport slave (
        output rows_in,
        input  columns_out, key_code, key_valid, key_release, key_down, multi_key
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sampling, per-sweep debounce
// and one-shot press/release keycode events.
module keypad_scanner #(
    parameter int unsigned SETTLE_CYCLES  = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic               clk,
    input  logic               reset,
    keypad_scanner_if.master   bus
);
    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES);
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic {DRIVE, SAMPLE} scan_state_t;
    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_kind_t;

    logic [3:0]       rows_meta, rows_sync;
    scan_state_t      state, state_n;
    logic [CNT_W-1:0] settle_cnt, settle_cnt_n;
    logic [1:0]       col_idx, col_idx_n;
    logic [3:0]       columns_q, columns_n;
    logic             acc_hit, acc_hit_n, acc_multi, acc_multi_n;
    logic [3:0]       acc_code, acc_code_n;
    res_kind_t        prev_kind, prev_kind_n, sweep_kind;
    logic [3:0]       prev_code, prev_code_n, sweep_code;
    logic [DEB_W-1:0] deb_cnt, deb_cnt_n;
    logic [3:0]       key_code_q, key_code_n;
    logic             key_valid_q, key_valid_n, key_release_q, key_release_n;
    logic             key_down_q, key_down_n, multi_key_q, multi_key_n;
    logic             row_single;
    logic [1:0]       row_idx;

    // Column/row position to keycode.
    function automatic logic [3:0] keymap(input logic [1:0] col, input logic [1:0] row);
        case ({col, row})
            4'b00_00: keymap = 4'h1;  4'b00_01: keymap = 4'h4;
            4'b00_10: keymap = 4'h7;  4'b00_11: keymap = 4'hE;
            4'b01_00: keymap = 4'h2;  4'b01_01: keymap = 4'h5;
            4'b01_10: keymap = 4'h8;  4'b01_11: keymap = 4'h0;
            4'b10_00: keymap = 4'h3;  4'b10_01: keymap = 4'h6;
            4'b10_10: keymap = 4'h9;  4'b10_11: keymap = 4'hF;
            4'b11_00: keymap = 4'hA;  4'b11_01: keymap = 4'hB;
            4'b11_10: keymap = 4'hC;  default:  keymap = 4'hD;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            rows_meta     <= '0;
            rows_sync     <= '0;
            state         <= DRIVE;
            settle_cnt    <= '0;
            col_idx       <= '0;
            columns_q     <= 4'b0001;
            acc_hit       <= 1'b0;
            acc_multi     <= 1'b0;
            acc_code      <= '0;
            prev_kind     <= RES_NONE;
            prev_code     <= '0;
            deb_cnt       <= '0;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
            key_down_q    <= 1'b0;
            multi_key_q   <= 1'b0;
        end else begin
            rows_meta     <= bus.rows_in;
            rows_sync     <= rows_meta;
            state         <= state_n;
            settle_cnt    <= settle_cnt_n;
            col_idx       <= col_idx_n;
            columns_q     <= columns_n;
            acc_hit       <= acc_hit_n;
            acc_multi     <= acc_multi_n;
            acc_code      <= acc_code_n;
            prev_kind     <= prev_kind_n;
            prev_code     <= prev_code_n;
            deb_cnt       <= deb_cnt_n;
            key_code_q    <= key_code_n;
            key_valid_q   <= key_valid_n;
            key_release_q <= key_release_n;
            key_down_q    <= key_down_n;
            multi_key_q   <= multi_key_n;
        end
    end

    always_comb begin
        row_single = (rows_sync != 4'd0) && ((rows_sync & (rows_sync - 4'd1)) == 4'd0);
        case (rows_sync)
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    // Scan sequencing, sweep accumulation and debounce of the completed sweep.
    always_comb begin
        state_n       = state;
        settle_cnt_n  = settle_cnt;
        col_idx_n     = col_idx;
        columns_n     = columns_q;
        acc_hit_n     = acc_hit;
        acc_multi_n   = acc_multi;
        acc_code_n    = acc_code;
        prev_kind_n   = prev_kind;
        prev_code_n   = prev_code;
        deb_cnt_n     = deb_cnt;
        key_code_n    = key_code_q;
        key_valid_n   = 1'b0;
        key_release_n = 1'b0;
        key_down_n    = key_down_q;
        multi_key_n   = multi_key_q;
        sweep_kind    = RES_NONE;
        sweep_code    = '0;

        case (state)
            DRIVE: begin
                if (settle_cnt == CNT_W'(SETTLE_CYCLES - 2)) state_n = SAMPLE;
                else settle_cnt_n = settle_cnt + CNT_W'(1);
            end
            default: begin
                state_n      = DRIVE;
                settle_cnt_n = '0;
                col_idx_n    = col_idx + 2'd1;
                columns_n    = {columns_q[2:0], columns_q[3]};

                if (row_single) begin
                    if (acc_hit) acc_multi_n = 1'b1;
                    else begin
                        acc_hit_n  = 1'b1;
                        acc_code_n = keymap(col_idx, row_idx);
                    end
                end else if (rows_sync != 4'd0) begin
                    acc_multi_n = 1'b1;
                end

                if (col_idx == 2'd3) begin
                    if (acc_multi_n)    sweep_kind = RES_MULTI;
                    else if (acc_hit_n) sweep_kind = RES_KEY;
                    if (sweep_kind == RES_KEY) sweep_code = acc_code_n;
                    acc_hit_n   = 1'b0;
                    acc_multi_n = 1'b0;
                    acc_code_n  = '0;
                    prev_kind_n = sweep_kind;
                    prev_code_n = sweep_code;

                    if (sweep_kind == RES_MULTI) begin
                        deb_cnt_n   = '0;
                        multi_key_n = 1'b1;
                    end else begin
                        multi_key_n = 1'b0;
                        if (sweep_kind == prev_kind && sweep_code == prev_code)
                            deb_cnt_n = (deb_cnt == DEB_W'(DEBOUNCE_SCANS)) ? deb_cnt
                                                                             : deb_cnt + DEB_W'(1);
                        else
                            deb_cnt_n = DEB_W'(1);

                        if (deb_cnt_n == DEB_W'(DEBOUNCE_SCANS)) begin
                            if (sweep_kind == RES_NONE) begin
                                if (key_down_q) begin
                                    key_down_n    = 1'b0;
                                    key_release_n = 1'b1;
                                end
                            end else if (!key_down_q) begin
                                key_down_n  = 1'b1;
                                key_code_n  = sweep_code;
                                key_valid_n = 1'b1;
                            end else if (sweep_code != key_code_q) begin
                                key_code_n    = sweep_code;
                                key_valid_n   = 1'b1;
                                key_release_n = 1'b1;
                            end
                        end
                    end
                end
            end
        endcase
    end

    assign bus.columns_out = columns_q;
    assign bus.key_code    = key_code_q;
    assign bus.key_valid   = key_valid_q;
    assign bus.key_release = key_release_q;
    assign bus.key_down    = key_down_q;
    assign bus.multi_key   = multi_key_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Sweep-level bench for keypad_scanner: a pressed-key set drives the rows and a
// history-based debounce model predicts the event outputs.
module tb_keypad_scanner;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned DEB    = 3;
    localparam int unsigned SWEEP  = 4 * SETTLE;

    logic        clk;
    logic        reset;
    logic [15:0] pressed;
    logic [3:0]  rows_drv;
    logic [1:0]  kcol [16];
    logic [1:0]  krow [16];

    int n_cmp;
    int n_mis;

    int          hist [$];
    logic        m_down;
    logic        m_multi;
    logic [3:0]  m_code;

    keypad_scanner_if bus();

    keypad_scanner #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(DEB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a pressed key connects its column to its row.
    always_comb begin
        rows_drv = '0;
        for (int c = 0; c < 16; c++)
            if (pressed[c] && bus.columns_out[kcol[c]]) rows_drv[krow[c]] = 1'b1;
    end
    assign bus.rows_in = rows_drv;

    function automatic logic [3:0] key_at(input int col, input int row);
        logic [3:0] layout [16];
        layout = '{4'h1, 4'h4, 4'h7, 4'hE,
                   4'h2, 4'h5, 4'h8, 4'h0,
                   4'h3, 4'h6, 4'h9, 4'hF,
                   4'hA, 4'hB, 4'hC, 4'hD};
        return layout[col * 4 + row];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_columns", 32'(bus.columns_out), 32'h1);
        check("rst_key_code", 32'(bus.key_code), 32'h0);
        check("rst_key_valid", 32'(bus.key_valid), 32'h0);
        check("rst_key_release", 32'(bus.key_release), 32'h0);
        check("rst_key_down", 32'(bus.key_down), 32'h0);
        check("rst_multi_key", 32'(bus.multi_key), 32'h0);
    endtask

    // Assert reset for nclk edges; returns in the first cycle of a fresh sweep.
    task automatic do_reset(input int nclk);
        reset = 1'b1;
        repeat (nclk) @(posedge clk);
        #1 reset = 1'b0;
        hist.delete();
        m_down  = 1'b0;
        m_multi = 1'b0;
        m_code  = 4'h0;
        check_reset_values();
    endtask

    // One full sweep with a constant set of pressed keys.
    task automatic run_sweep(input logic [15:0] mask);
        int   res;
        int   nkeys;
        logic confirmed;
        logic exp_v, exp_r;
        pressed = mask;

        nkeys = $countones(mask);
        res = -1;
        if (nkeys == 1) begin
            for (int i = 0; i < 16; i++) if (mask[i]) res = i;
        end else if (nkeys > 1) begin
            res = -2;
        end
        hist.push_back(res);
        if (hist.size() > DEB) void'(hist.pop_front());
        confirmed = (res != -2) && (hist.size() == DEB);
        for (int i = 0; i < hist.size(); i++) if (hist[i] != res) confirmed = 1'b0;

        exp_v   = 1'b0;
        exp_r   = 1'b0;
        m_multi = (res == -2);
        if (confirmed) begin
            if (res == -1) begin
                if (m_down) begin
                    exp_r  = 1'b1;
                    m_down = 1'b0;
                end
            end else begin
                if (!m_down) exp_v = 1'b1;
                else if (4'(res) != m_code) begin
                    exp_v = 1'b1;
                    exp_r = 1'b1;
                end
                m_down = 1'b1;
                m_code = 4'(res);
            end
        end

        for (int j = 1; j <= SWEEP; j++) begin
            @(posedge clk);
            #1;
            check("columns_out", 32'(bus.columns_out), 32'(4'b0001 << ((j % SWEEP) / SETTLE)));
            if (j < SWEEP) begin
                check("valid_mid_sweep", 32'(bus.key_valid), 32'h0);
                check("release_mid_sweep", 32'(bus.key_release), 32'h0);
            end else begin
                check("key_valid", 32'(bus.key_valid), 32'(exp_v));
                check("key_release", 32'(bus.key_release), 32'(exp_r));
                check("key_code", 32'(bus.key_code), 32'(m_code));
                check("key_down", 32'(bus.key_down), 32'(m_down));
                check("multi_key", 32'(bus.multi_key), 32'(m_multi));
            end
        end
    endtask

    function automatic logic [15:0] kbit(input int code);
        return 16'(1) << code;
    endfunction

    initial begin
        logic [15:0] cur;
        int          r;
        n_cmp   = 0;
        n_mis   = 0;
        pressed = '0;
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) begin
                kcol[key_at(c, rr)] = 2'(c);
                krow[key_at(c, rr)] = 2'(rr);
            end

        do_reset(3);

        // Idle sweeps: rotation only, no events.
        repeat (2) run_sweep('0);

        // Press '5', hold, release.
        repeat (8) run_sweep(kbit(5));
        repeat (4) run_sweep('0);

        // Bouncing 'F' then solid.
        for (int i = 0; i < 6; i++) run_sweep((i % 2 == 0) ? kbit(15) : 16'h0);
        repeat (3) run_sweep(kbit(15));
        repeat (4) run_sweep('0);

        // '1' and 'D' together, then 'D' released.
        repeat (3) run_sweep(kbit(1) | kbit(13));
        repeat (4) run_sweep(kbit(1));
        repeat (3) run_sweep('0);

        // Roll-over from '1' straight to '9'.
        repeat (3) run_sweep(kbit(1));
        repeat (3) run_sweep(kbit(9));
        repeat (3) run_sweep('0);

        // Hold 'A' to stable, reset for one clock, 'A' must re-debounce.
        repeat (4) run_sweep(kbit(10));
        do_reset(1);
        repeat (4) run_sweep(kbit(10));
        repeat (3) run_sweep('0);

        // Randomized key activity with persistence so presses can confirm.
        cur = '0;
        for (int s = 0; s < 60; s++) begin
            r = int'($urandom_range(0, 9));
            if (r == 5 || r == 6) cur = '0;
            else if (r == 7 || r == 8) cur = kbit(int'($urandom_range(0, 15)));
            else if (r == 9) cur = kbit(int'($urandom_range(0, 15))) | kbit(int'($urandom_range(0, 15)));
            run_sweep(cur);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the column lines of the 4x4 matrix keypad and samples the row lines.
- Debounces the scan result and emits one registered keycode event per press and per release.
- Sits between the keypad pins and the calculator input logic, and drives the same one-hot column/row convention used by the keypad decode path.
- Keycode map (column one-hot / row one-hot -> code):
  - col 0001: rows 0001..1000 -> 1, 4, 7, E
  - col 0010: rows 0001..1000 -> 2, 5, 8, 0
  - col 0100: rows 0001..1000 -> 3, 6, 9, F
  - col 1000: rows 0001..1000 -> A, B, C, D

Parameters:
SETTLE_CYCLES, 1000, clocks each column is driven before rows are sampled; legal minimum 3.
DEBOUNCE_SCANS, 4, consecutive identical full sweeps required before the stable state changes; legal minimum 1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
rows_in  in  4  raw keypad row lines, active-high, asynchronous to clk
columns_out  out  4  one-hot column drive, active-high
key_code  out  4  code of the currently/last stable key
key_valid  out  1  one-cycle pulse: new stable key press, key_code valid this cycle
key_release  out  1  one-cycle pulse: stable key released
key_down  out  1  level: a stable key is currently held
multi_key  out  1  level: last completed sweep saw more than one key

Behaviour:
- Input synchronizer:
  - rows_in passes through a 2-flop synchronizer; only rows_sync is used internally.
  - The synchronizer flops reset to 0.
- Reset values:
  - columns_out = 0001, key_code = 0, all other outputs 0.
  - Settle counter, column index, sweep accumulator, debounce counter and stable state are all cleared.
  - Reset mid-sweep or mid-press aborts everything; a key still held after reset must re-debounce from zero.
- Scan FSM, states DRIVE and SAMPLE:
  - DRIVE: hold columns_out, count settle_cnt from 0 to SETTLE_CYCLES-2, then go to SAMPLE.
  - SAMPLE (one cycle): evaluate rows_sync for the current column.
    - rows_sync == 0: no hit.
    - Exactly one bit set: record the hit (code from the map). If a hit was already recorded this sweep, set the sweep-multi flag instead.
    - More than one bit set: set the sweep-multi flag.
  - After SAMPLE: rotate columns_out left (1000 wraps to 0001), clear settle_cnt, return to DRIVE.
  - Each column is driven for exactly SETTLE_CYCLES clocks.
  - Sweep period = 4*SETTLE_CYCLES clocks; scanning never stops.
- Sweep result, formed at the SAMPLE of column 1000:
  - Possible results: NONE, KEY(code), or MULTI.
  - The result is registered into the debounce stage on the following clock, and the accumulator clears for the next sweep.
- Debounce:
  - If the result equals the previous sweep result, deb_cnt increments, saturating at DEBOUNCE_SCANS. Otherwise deb_cnt = 1.
  - A result is confirmed when deb_cnt reaches DEBOUNCE_SCANS. With DEBOUNCE_SCANS = 1, every sweep is confirmed.
  - MULTI sweeps never confirm: they reset deb_cnt, set multi_key, and leave key_down, key_code and the stable state unchanged.
  - multi_key clears at the next non-MULTI sweep.
- Stable-state transitions, evaluated in the cycle a result is confirmed:
  - IDLE -> KEY(c): key_code <= c, key_down <= 1, key_valid pulses in that same cycle.
  - KEY(c) -> NONE: key_down <= 0, key_release pulses; key_code holds c.
  - KEY(c) -> KEY(d), d != c (roll-over without a confirmed release): key_release and key_valid pulse in the same cycle, key_code <= d.
  - Repeated confirmation of the current stable state produces no pulse; there is no auto-repeat.
- Latency: key_valid asserts 1 clock after the column-1000 SAMPLE of the DEBOUNCE_SCANS-th consecutive matching sweep.

Test Plan:
All scenarios use SETTLE_CYCLES=4 and DEBOUNCE_SCANS=3 (16-clock sweep); the bench model drives rows_in from columns_out.
- Reset, then idle: columns_out = 0001 -> 0010 -> 0100 -> 1000 -> 0001, each held 4 clocks; no pulses; key_code = 0.
- Press '5' (rows_in = 0010 while columns_out = 0010) from sweep start: exactly one key_valid with key_code = 5 at the end of the 3rd sweep; key_down = 1; no further pulses while held for 5 more sweeps.
- Release '5': key_release pulses after 3 empty sweeps; key_down = 0; key_code stays 5.
- Bounce '#' (col 0100, row 1000) present in alternating sweeps for 6 sweeps, then solid: no pulse until 3 consecutive hits; key_valid with key_code = F.
- Press '1' and 'D' together: multi_key = 1, no key_valid. Then release 'D': key_valid with code 1 after 3 sweeps, and multi_key clears after the first clean sweep.
- Hold 'A' (col 1000, row 0001) to stable, then assert reset for 1 clock: all outputs return to their reset values, and a fresh key_valid with code A arrives 3 sweeps after reset deasserts.
